// File: rtl/vx_onehot_accum_decoder.sv
// Accumulates one-hot decoded indices over a beat group and emits the OR mask with its popcount.
// Optional group error checking is compiled in with `define VX_ONEHOT_DECODER_CHECK_EN.
module vx_onehot_accum_decoder #(
    parameter int N       = 8,
    parameter int REVERSE = 0,
    parameter int LN      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid_in,
    input  logic [LN-1:0]            data_in,
    input  logic                     last_in,
    output logic                     ready_in,
    output logic                     valid_out,
    output logic [N-1:0]             data_out,
    output logic [$clog2(N+1)-1:0]   count_out,
    input  logic                     ready_out,
    output logic                     err_out
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Indices at or beyond N match no position and decode to all-zeros.
    function automatic logic [N-1:0] decode(input logic [LN-1:0] idx);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(idx) == i) begin
                m[(REVERSE != 0) ? (N - 1 - i) : i] = 1'b1;
            end
        end
        return m;
    endfunction

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [CW-1:0]  acc_cnt_q, acc_cnt_d;
    logic [N-1:0]   out_q, out_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           fire_in;
    logic [N-1:0]   dec;
    logic [N-1:0]   acc_next;
    logic [CW-1:0]  cnt_next;

    assign ready_in  = (state_q == ACCUM) || ready_out;
    assign fire_in   = valid_in && ready_in;
    assign dec       = decode(data_in);
    assign acc_next  = acc_q | dec;
    // Count only bits that were not already present, so duplicates never overcount.
    assign cnt_next  = acc_cnt_q + CW'(|(dec & ~acc_q));

    assign valid_out = (state_q == HOLD);
    assign data_out  = out_q;
    assign count_out = cnt_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        if ((state_q == HOLD) && ready_out) begin
            state_d = ACCUM;
        end
        if (fire_in) begin
            if (last_in) begin
                state_d   = HOLD;
                out_d     = acc_next;
                cnt_d     = cnt_next;
                acc_d     = '0;
                acc_cnt_d = '0;
            end else begin
                acc_d     = acc_next;
                acc_cnt_d = cnt_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            acc_cnt_q <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef VX_ONEHOT_DECODER_CHECK_EN
    logic grp_err_q, grp_err_d;
    logic err_q, err_d;
    logic beat_err;

    assign beat_err = (int'(data_in) >= N) || (|(dec & acc_q));
    assign err_out  = err_q;

    // The group flag collects beat errors; it moves to err_out with the group on the last beat.
    always_comb begin
        grp_err_d = grp_err_q;
        err_d     = err_q;
        if ((state_q == HOLD) && ready_out) begin
            err_d = 1'b0;
        end
        if (fire_in) begin
            if (last_in) begin
                err_d     = grp_err_q | beat_err;
                grp_err_d = 1'b0;
            end else begin
                grp_err_d = grp_err_q | beat_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grp_err_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            grp_err_q <= grp_err_d;
            err_q     <= err_d;
        end
    end
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_vx_onehot_accum_decoder.sv
// Bench for vx_onehot_accum_decoder: three configurations share one beat stream and a queue-based model.
module tb_vx_onehot_accum_decoder;

`ifdef VX_ONEHOT_DECODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       valid_in;
    logic [2:0] data_in;
    logic       last_in;
    logic       ready_out;

    logic [2:0] rdy, vld, err;
    logic [7:0] d8, d8r;
    logic [5:0] d6;
    logic [3:0] c8, c8r;
    logic [2:0] c6;

    vx_onehot_accum_decoder #(.N(8), .REVERSE(0)) dut8 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
        .ready_in(rdy[0]), .valid_out(vld[0]), .data_out(d8), .count_out(c8),
        .ready_out(ready_out), .err_out(err[0]));

    vx_onehot_accum_decoder #(.N(8), .REVERSE(1)) dut8r (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
        .ready_in(rdy[1]), .valid_out(vld[1]), .data_out(d8r), .count_out(c8r),
        .ready_out(ready_out), .err_out(err[1]));

    vx_onehot_accum_decoder #(.N(6), .REVERSE(0)) dut6 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
        .ready_in(rdy[2]), .valid_out(vld[2]), .data_out(d6), .count_out(c6),
        .ready_out(ready_out), .err_out(err[2]));

    logic [7:0] obs_d [3];
    logic [3:0] obs_c [3];
    assign obs_d[0] = d8;
    assign obs_d[1] = d8r;
    assign obs_d[2] = {2'b00, d6};
    assign obs_c[0] = c8;
    assign obs_c[1] = c8r;
    assign obs_c[2] = {1'b0, c6};

    typedef struct packed {
        logic [2:0][7:0] d;
        logic [2:0][3:0] c;
        logic [2:0]      e;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    int   cfg_n   [3] = '{8, 8, 6};
    int   cfg_rev [3] = '{0, 1, 0};
    logic [7:0] macc [3];
    logic       merr [3];
    logic       m_valid;

    function automatic logic [7:0] mdec(input int idx, input int n, input int rev);
        if (idx >= n) return 8'h00;
        return 8'h01 << ((rev != 0) ? (n - 1 - idx) : idx);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            macc[c] = 8'h00;
            merr[c] = 1'b0;
        end
        m_valid = 1'b0;
        sbq.delete();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One beat presented for one cycle; if it completes a group the result is checked right after the edge.
    task automatic beat(input int idx, input bit last, input bit rout);
        exp_t e;
        bit   acc_ok;
        bit   pushed;
        logic [7:0] dd;
        bit   bad;
        pushed    = 1'b0;
        valid_in  = 1'b1;
        data_in   = idx[2:0];
        last_in   = last;
        ready_out = rout;
        acc_ok    = !m_valid || rout;
        #1;
        checks++;
        if (rdy !== {3{acc_ok}}) begin
            errors++;
            $display("FAIL ready_in idx=%0d got %b want %b", idx, rdy, {3{acc_ok}});
        end
        if (acc_ok) begin
            for (int c = 0; c < 3; c++) begin
                dd  = mdec(idx, cfg_n[c], cfg_rev[c]);
                bad = (idx >= cfg_n[c]) || ((dd & macc[c]) != 8'h00);
                if (last) begin
                    e.d[c]  = macc[c] | dd;
                    e.c[c]  = 4'($countones(macc[c] | dd));
                    e.e[c]  = CHK && (merr[c] || bad);
                    macc[c] = 8'h00;
                    merr[c] = 1'b0;
                end else begin
                    macc[c] = macc[c] | dd;
                    merr[c] = merr[c] || bad;
                end
            end
            if (last) begin
                sbq.push_back(e);
                pushed = 1'b1;
            end
        end
        if (acc_ok && last) m_valid = 1'b1;
        else if (m_valid && rout) m_valid = 1'b0;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
        if (pushed) begin
            e = sbq.pop_front();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (vld[c] !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_out[%0d] got %b want 1", c, vld[c]);
                end
                checks++;
                if (obs_d[c] !== e.d[c]) begin
                    errors++;
                    $display("FAIL data_out[%0d] got %b want %b", c, obs_d[c], e.d[c]);
                end
                checks++;
                if (obs_c[c] !== e.c[c]) begin
                    errors++;
                    $display("FAIL count_out[%0d] got %0d want %0d", c, obs_c[c], e.c[c]);
                end
                checks++;
                if (err[c] !== e.e[c]) begin
                    errors++;
                    $display("FAIL err_out[%0d] got %b want %b", c, err[c], e.e[c]);
                end
            end
        end
    endtask

    task automatic idle(input bit rout, input int n);
        valid_in  = 1'b0;
        ready_out = rout;
        for (int i = 0; i < n; i++) begin
            if (m_valid && rout) m_valid = 1'b0;
            cycle();
            checks++;
            if (vld !== {3{m_valid}}) begin
                errors++;
                $display("FAIL idle valid_out got %b want %b", vld, {3{m_valid}});
            end
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({vld, err, d8, d8r, d6, c8, c8r, c6} !== '0 || rdy !== 3'b111) begin
            errors++;
            $display("FAIL %s outputs vld=%b err=%b d8=%h d8r=%h d6=%h c=%0d/%0d/%0d rdy=%b want all 0 rdy=111",
                     tag, vld, err, d8, d8r, d6, c8, c8r, c6, rdy);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        valid_in  = 1'b0;
        data_in   = 3'd0;
        last_in   = 1'b0;
        ready_out = 1'b1;
        model_reset();
        cycle();
        cycle();
        check_zero("reset");
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        beat(1, 0, 1);
        beat(4, 0, 1);
        beat(6, 1, 1);
        checks++;
        if (d8 !== 8'b0101_0010 || c8 !== 4'd3) begin
            errors++;
            $display("FAIL basic d8 got %b/%0d want 01010010/3", d8, c8);
        end
        idle(1, 1);
        beat(0, 1, 1);
        checks++;
        if (d8r !== 8'b1000_0000 || c8r !== 4'd1) begin
            errors++;
            $display("FAIL reverse d8r got %b/%0d want 10000000/1", d8r, c8r);
        end
        idle(1, 2);
    endtask

    task automatic test_dup_range();
        beat(3, 0, 1);
        beat(3, 0, 1);
        beat(7, 1, 1);
        checks++;
        if (d6 !== 6'b00_1000 || c6 !== 3'd1 || err[2] !== CHK) begin
            errors++;
            $display("FAIL dup_range d6 got %b/%0d err=%b want 001000/1 err=%b", d6, c6, err[2], CHK);
        end
        beat(1, 0, 1);
        beat(2, 1, 1);
        checks++;
        if (err !== 3'b000) begin
            errors++;
            $display("FAIL clean_group err_out got %b want 000", err);
        end
        idle(1, 1);
    endtask

    task automatic test_full();
        beat(0, 0, 1);
        for (int i = 1; i < 7; i++) beat(i, 0, 1);
        beat(0, 0, 1);
        beat(7, 1, 1);
        checks++;
        if (c8 !== 4'd8 || d8 !== 8'hFF || c6 !== 3'd6) begin
            errors++;
            $display("FAIL full count got %0d/%h/%0d want 8/ff/6", c8, d8, c6);
        end
        idle(1, 1);
    endtask

    task automatic test_stall();
        beat(5, 1, 1);
        valid_in  = 1'b1;
        data_in   = 3'd5;
        last_in   = 1'b0;
        ready_out = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (rdy !== 3'b000) begin
                errors++;
                $display("FAIL stall ready_in got %b want 000", rdy);
            end
            cycle();
            checks++;
            if (d8 !== 8'b0010_0000 || vld !== 3'b111 || c8 !== 4'd1) begin
                errors++;
                $display("FAIL stall hold d8 got %b vld=%b cnt=%0d want 00100000 111 1", d8, vld, c8);
            end
        end
        beat(2, 1, 1);
        checks++;
        if (d8 !== 8'b0000_0100 || vld[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall release d8 got %b vld=%b want 00000100 1", d8, vld[0]);
        end
        idle(1, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) beat((i * 3) % 8, 1, 1);
        beat(2, 0, 1);
        beat(6, 1, 1);
        idle(1, 2);
    endtask

    task automatic test_reset_mid();
        beat(4, 1, 1);
        beat(1, 0, 1);
        beat(3, 0, 1);
        reset_n = 1'b0;
        #1;
        check_zero("reset_mid");
        model_reset();
        cycle();
        reset_n = 1'b1;
        cycle();
        beat(5, 1, 1);
        checks++;
        if (d8 !== 8'b0010_0000 || c8 !== 4'd1) begin
            errors++;
            $display("FAIL reset_mid group d8 got %b/%0d want 00100000/1", d8, c8);
        end
        idle(1, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dup_range();
        test_full();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
